// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage data-memory sequencer with req/ack bus, stall and exceptions
//
// Purpose: drives one variable-latency req/ack data-bus access per load/store held in EX/MEM.
//   The pipeline is stalled until the access completes. Stores get byte enables and
//   lane-replicated data. Loads are returned sign- or zero-extended.
//   Misaligned or illegal accesses and bus timeouts are reported as 1-cycle pulses.
// Ports:
//   clk, n_rst                      clock (rising edge), asynchronous active-low reset
//   MemReadM, MemWriteM             load / store request (store wins if both are set)
//   ALUResultM, WriteDataM, funct3M byte address, store data, access size/sign
//   StallM                          hold EX/MEM and all upstream pipeline registers
//   ReadDataM                       extended load data, valid in DONE and held afterwards
//   bus_req/we/addr/be/wdata        registered bus request
//   bus_ack, bus_rdata              bus completion and read word
//   misalign_exc, timeout_exc       1-cycle exception pulses
module dmem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  funct3M,
  output logic        StallM,
  output logic [31:0] ReadDataM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        misalign_exc,
  output logic        timeout_exc
);

  // The counter only needs to reach TIMEOUT_CYCLES-1: it holds the number of REQ cycles
  // already spent without an ack.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    f3Lat;
  logic [1:0]    addrLo;

  logic        access;
  logic        f3Legal;
  logic        aligned;
  logic        legal;
  logic [3:0]  beNext;
  logic [31:0] wdataNext;
  logic [7:0]  rdByte;
  logic [15:0] rdHalf;
  logic [31:0] loadData;

  assign access = MemReadM | MemWriteM;

  always_comb begin
    f3Legal = 1'b0;
    case (funct3M)
      3'b000, 3'b001, 3'b010: f3Legal = 1'b1;
      3'b100, 3'b101:         f3Legal = ~MemWriteM;
      default:                f3Legal = 1'b0;
    endcase
  end

  always_comb begin
    aligned   = 1'b0;
    beNext    = 4'b1111;
    wdataNext = WriteDataM;
    case (funct3M[1:0])
      2'b00: begin
        aligned   = 1'b1;
        beNext    = 4'b0001 << ALUResultM[1:0];
        wdataNext = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        aligned   = ~ALUResultM[0];
        beNext    = 4'b0011 << ALUResultM[1:0];
        wdataNext = {2{WriteDataM[15:0]}};
      end
      2'b10: aligned = (ALUResultM[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign legal = f3Legal & aligned;

  // Gated by n_rst so the pipeline is released while reset is held, even though the
  // EX/MEM register may still present the aborted access.
  assign StallM = n_rst & (((state == IDLE) & access & legal) | (state == REQ));

  // Load extraction from the lane chosen by the latched address offset.
  always_comb begin
    rdByte = bus_rdata[7:0];
    case (addrLo)
      2'b00: rdByte = bus_rdata[7:0];
      2'b01: rdByte = bus_rdata[15:8];
      2'b10: rdByte = bus_rdata[23:16];
      2'b11: rdByte = bus_rdata[31:24];
      default: rdByte = bus_rdata[7:0];
    endcase
    rdHalf = addrLo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3Lat)
      3'b000:  loadData = {{24{rdByte[7]}}, rdByte};
      3'b001:  loadData = {{16{rdHalf[15]}}, rdHalf};
      3'b100:  loadData = {24'h0, rdByte};
      3'b101:  loadData = {16'h0, rdHalf};
      default: loadData = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      f3Lat        <= 3'b000;
      addrLo       <= 2'b00;
      ReadDataM    <= 32'h0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= 32'h0;
      bus_be       <= 4'b0000;
      bus_wdata    <= 32'h0;
      misalign_exc <= 1'b0;
      timeout_exc  <= 1'b0;
    end else begin
      misalign_exc <= 1'b0;
      timeout_exc  <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (legal) begin
              bus_req   <= 1'b1;
              bus_we    <= MemWriteM;
              bus_addr  <= {ALUResultM[31:2], 2'b00};
              bus_be    <= beNext;
              bus_wdata <= wdataNext;
              f3Lat     <= funct3M;
              addrLo    <= ALUResultM[1:0];
              cnt       <= '0;
              state     <= REQ;
            end else begin
              misalign_exc <= 1'b1;
            end
          end
        end
        REQ: begin
          // An ack in the final permitted cycle still completes the access.
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) ReadDataM <= loadData;
            state <= DONE;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
            bus_req     <= 1'b0;
            timeout_exc <= 1'b1;
            if (!bus_we) ReadDataM <= 32'h0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [2:0]  funct3M;
  logic        StallM;
  logic [31:0] ReadDataM;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        misalign_exc;
  logic        timeout_exc;

  int          nChecks = 0;
  int          nFail = 0;
  logic [31:0] expRead = 32'h0;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .n_rst(n_rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .funct3M(funct3M),
    .StallM(StallM), .ReadDataM(ReadDataM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .misalign_exc(misalign_exc), .timeout_exc(timeout_exc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes from funct3
  function automatic int mSize(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit mLegal(input bit we, input logic [2:0] f3, input logic [31:0] a);
    bit okF3;
    okF3 = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return okF3 && ((int'(a[2:0]) % mSize(f3)) == 0);
  endfunction

  function automatic logic [3:0] mBe(input logic [2:0] f3, input logic [31:0] a);
    int mask;
    mask = (1 << mSize(f3)) - 1;
    return 4'((mask << int'(a[1:0])) & 15);
  endfunction

  function automatic logic [31:0] mWdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'((wd >> (8 * (i % mSize(f3)))) & 32'hFF);
    return r;
  endfunction

  function automatic logic [31:0] mLoad(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] rd);
    longint raw;
    int     bits;
    bits = 8 * mSize(f3);
    if (bits == 32) return rd;
    raw = longint'((rd >> (8 * int'(a[1:0])))) & ((64'sd1 << bits) - 1);
    if (!f3[2] && raw[bits-1]) raw = raw - (64'sd1 << bits);
    return raw[31:0];
  endfunction

  // One access from the IDLE cycle through DONE. ackAt = REQ cycle (1-based) in which
  // the bus acks; anything beyond TMO means the bus never answers.
  task automatic doAccess(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f3,
                          input int ackAt, input logic [31:0] rdata);
    bit acc, legal, to;
    int nReq;
    acc   = rd | wr;
    legal = acc && mLegal(wr, f3, a);
    @(posedge clk); #1;
    MemReadM = rd; MemWriteM = wr; ALUResultM = a; WriteDataM = wd; funct3M = f3;
    bus_ack = 1'($urandom_range(0, 1));   // ack outside REQ must be ignored
    bus_rdata = $urandom;
    #1;
    check("stall_idle", StallM, legal);
    if (!legal) begin
      @(posedge clk); #1;
      check("misalign_exc", misalign_exc, acc);
      check("no_bus_req", bus_req, 0);
      check("stall_after_illegal", StallM, 0);
      MemReadM = 0; MemWriteM = 0; bus_ack = 0;
      return;
    end
    to   = (ackAt > TMO);
    nReq = to ? TMO : ackAt;
    for (int c = 1; c <= nReq; c++) begin
      @(posedge clk); #1;
      check("req_high", bus_req, 1);
      check("stall_req", StallM, 1);
      check("bus_we", bus_we, wr);
      check("bus_addr", bus_addr, {a[31:2], 2'b00});
      check("bus_be", bus_be, mBe(f3, a));
      if (wr) check("bus_wdata", bus_wdata, mWdata(f3, wd));
      check("no_exc_req", {misalign_exc, timeout_exc}, 0);
      bus_ack   = (c == ackAt);
      bus_rdata = (c == ackAt) ? rdata : $urandom;
    end
    @(posedge clk); #1;
    bus_ack = 1'($urandom_range(0, 1));
    if (!wr) expRead = to ? 32'h0 : mLoad(f3, a, rdata);
    check("req_low_done", bus_req, 0);
    check("stall_done", StallM, 0);
    check("timeout_exc", timeout_exc, to);
    check("read_data", ReadDataM, expRead);
  endtask

  initial begin
    n_rst = 1; MemReadM = 0; MemWriteM = 0; ALUResultM = 0; WriteDataM = 0;
    funct3M = 0; bus_ack = 0; bus_rdata = 0;
    #2 n_rst = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus_req", bus_req, 0);
    check("rst_stall", StallM, 0);
    check("rst_read_data", ReadDataM, 0);
    check("rst_bus_be", bus_be, 0);
    check("rst_exc", {misalign_exc, timeout_exc}, 0);
    @(negedge clk) n_rst = 1;

    // Directed cases
    doAccess(1, 0, 32'h1000_0008, 32'h0, 3'b010, 1, 32'hDEAD_BEEF);       // lw
    doAccess(1, 0, 32'h1000_0003, 32'h0, 3'b000, 2, 32'h80FF_FFFF);       // lb
    doAccess(1, 0, 32'h1000_0003, 32'h0, 3'b100, 1, 32'h80FF_FFFF);       // lbu
    doAccess(0, 1, 32'h1000_0002, 32'h1234_ABCD, 3'b001, 5, 32'h0);       // sh, slow ack
    doAccess(1, 0, 32'h1000_0001, 32'h0, 3'b010, 1, 32'h0);               // misaligned lw
    doAccess(1, 0, 32'h1000_0000, 32'h0, 3'b011, 1, 32'h0);               // illegal funct3
    doAccess(0, 1, 32'h1000_0000, 32'h0, 3'b100, 1, 32'h0);               // illegal store size
    doAccess(1, 0, 32'h1000_0006, 32'h0, 3'b001, TMO + 4, 32'h0);         // lh, timeout
    doAccess(0, 1, 32'h2000_0004, 32'hCAFE_F00D, 3'b010, 3, 32'h0);       // sw
    doAccess(1, 0, 32'h2000_0002, 32'h0, 3'b101, 1, 32'h8001_7FFE);       // lhu
    doAccess(1, 1, 32'h2000_0001, 32'h0000_00A5, 3'b000, TMO, 32'h0);     // both set: sb, ack on last cycle

    // Reset in the middle of a request
    @(posedge clk); #1;
    MemReadM = 1; MemWriteM = 0; ALUResultM = 32'h3000_0000; funct3M = 3'b010;
    @(posedge clk); #1;
    check("pre_rst_req", bus_req, 1);
    n_rst = 0;
    #1;
    expRead = 32'h0;
    check("midrst_bus_req", bus_req, 0);
    check("midrst_stall", StallM, 0);
    check("midrst_read_data", ReadDataM, expRead);
    @(posedge clk); #1;
    MemReadM = 0;
    @(negedge clk) n_rst = 1;
    doAccess(1, 0, 32'h3000_0000, 32'h0, 3'b010, 2, 32'h0BAD_F00D);

    // Randomized accesses
    for (int i = 0; i < 60; i++) begin
      int op;
      bit rd, wr;
      logic [2:0] f3;
      int ackAt;
      op = int'($urandom_range(0, 9));
      rd = (op >= 1 && op <= 5) || op == 9;
      wr = (op >= 6);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        f3 = 3'($urandom_range(0, 2));
        if (!wr && $urandom_range(0, 1) == 1 && f3 != 3'd2) f3 = f3 | 3'b100;
      end
      ackAt = ($urandom_range(0, 9) == 0) ? TMO + 3 : int'($urandom_range(1, 5));
      doAccess(rd, wr, $urandom, $urandom, f3, ackAt, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
